// File: rtl/abstract_cmd_ctrl_pkg.sv
// abstract_cmd_ctrl_pkg: Debug Module types shared by the abstract-command path
package DM;

    typedef enum logic [2:0] {
        NONE         = 3'd0,
        BUSY         = 3'd1,
        NOTSUPPORTED = 3'd2,
        EXCEPTION    = 3'd3,
        HALTRESUME   = 3'd4,
        BUS          = 3'd5,
        OTHER        = 3'd7
    } cmderr_e;

    typedef enum logic [7:0] {
        ACCESS_REG   = 8'd0,
        QUICK_ACCESS = 8'd1,
        ACCESS_MEM   = 8'd2
    } cmdtype_e;

endpackage

// File: rtl/abstract_cmd_ctrl.sv
// abstract_cmd_ctrl: runs a decoded Access Register command on the halted hart, then optional progbuf
module abstract_cmd_ctrl
    import DM::*;
#(
    parameter int TimeoutCycles = 1024,
    parameter int DataWidth     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    input  cmdtype_e             cmd_type_i,
    input  logic [2:0]           aarsize_i,
    input  logic                 postexec_i,
    input  logic                 transfer_i,
    input  logic                 write_i,
    input  logic [15:0]          regno_i,
    input  logic                 unsupported_i,
    input  logic                 halted_i,
    input  logic                 cmderr_clear_i,
    input  logic [DataWidth-1:0] data0_i,
    output logic [DataWidth-1:0] data0_o,
    output logic                 data0_we_o,
    output logic                 reg_req_o,
    output logic                 reg_we_o,
    output logic [15:0]          reg_addr_o,
    output logic [DataWidth-1:0] reg_wdata_o,
    input  logic                 reg_gnt_i,
    input  logic                 reg_rvalid_i,
    input  logic [DataWidth-1:0] reg_rdata_i,
    input  logic                 reg_err_i,
    output logic                 exec_req_o,
    input  logic                 exec_ack_i,
    input  logic                 exec_done_i,
    input  logic                 exec_exc_i,
    output logic                 busy_o,
    output cmderr_e              cmderr_o
);

    typedef enum logic [2:0] {IDLE, ACC_REQ, ACC_WAIT, EXEC_REQ, EXEC_WAIT} state_e;

    localparam int CntW = $clog2(TimeoutCycles + 1);

    state_e          state;
    logic [CntW-1:0] cnt;
    logic            postexec_q;
    logic [2:0]      size_q;
    cmderr_e         ev;
    cmderr_e         err;
    logic            timeout;
    logic            abort;
    logic            rd_ok;

    function automatic logic [DataWidth-1:0] fit(input logic [2:0] size, input logic [DataWidth-1:0] d);
        return size == 3'd0 ? {{(DataWidth-8){1'b0}}, d[7:0]} :
               size == 3'd1 ? {{(DataWidth-16){1'b0}}, d[15:0]} : d;
    endfunction

    assign timeout    = cnt == CntW'(TimeoutCycles);
    assign busy_o     = state != IDLE;
    assign reg_req_o  = state == ACC_REQ;
    assign exec_req_o = state == EXEC_REQ;
    assign rd_ok      = state == ACC_WAIT && reg_rvalid_i && !reg_err_i && !reg_we_o;
    assign data0_we_o = rd_ok;
    assign data0_o    = rd_ok ? fit(size_q, reg_rdata_i) : '0;
    assign abort      = state != IDLE && ev != NONE;
    assign err        = ev != NONE ? ev : (state != IDLE && cmd_valid_i) ? BUSY : NONE;

    // Error raised by the current state; in busy states any error also aborts to IDLE
    always_comb begin
        ev = NONE;
        case (state)
            IDLE:      ev = !(cmd_valid_i && cmderr_o == NONE) ? NONE :
                            (unsupported_i || cmd_type_i != ACCESS_REG) ? NOTSUPPORTED :
                            !halted_i ? HALTRESUME : NONE;
            ACC_REQ:   ev = !halted_i ? HALTRESUME : reg_gnt_i ? NONE : timeout ? OTHER : NONE;
            ACC_WAIT:  ev = reg_rvalid_i ? (reg_err_i ? EXCEPTION : NONE) :
                            !halted_i ? HALTRESUME : timeout ? OTHER : NONE;
            EXEC_REQ:  ev = exec_ack_i ? NONE : timeout ? OTHER : NONE;
            EXEC_WAIT: ev = exec_exc_i ? EXCEPTION : exec_done_i ? NONE : timeout ? OTHER : NONE;
            default:   ev = NONE;
        endcase
    end

    // Command FSM with sticky cmderr, per-state timeout counter and latched request fields
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            cmderr_o    <= NONE;
            postexec_q  <= 1'b0;
            size_q      <= 3'd0;
            reg_we_o    <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
        end else begin
            cmderr_o <= (err != NONE && (cmderr_o == NONE || cmderr_clear_i)) ? err :
                        cmderr_clear_i ? NONE : cmderr_o;
            cnt      <= (state == IDLE || abort) ? '0 : cnt + 1'b1;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (cmd_valid_i && cmderr_o == NONE && ev == NONE && (transfer_i || postexec_i)) begin
                        state       <= transfer_i ? ACC_REQ : EXEC_REQ;
                        postexec_q  <= postexec_i;
                        size_q      <= aarsize_i;
                        reg_we_o    <= write_i;
                        reg_addr_o  <= regno_i;
                        reg_wdata_o <= fit(aarsize_i, data0_i);
                    end
                    ACC_REQ: if (reg_gnt_i) begin
                        state <= ACC_WAIT;
                        cnt   <= '0;
                    end
                    ACC_WAIT: if (reg_rvalid_i) begin
                        state <= postexec_q ? EXEC_REQ : IDLE;
                        cnt   <= '0;
                    end
                    EXEC_REQ: if (exec_ack_i) begin
                        state <= EXEC_WAIT;
                        cnt   <= '0;
                    end
                    EXEC_WAIT: if (exec_done_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_abstract_cmd_ctrl.sv
// tb_abstract_cmd_ctrl: randomized scoreboard bench for abstract_cmd_ctrl
module tb_abstract_cmd_ctrl;
    import DM::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    cmdtype_e    cmd_type_i = ACCESS_REG;
    logic [2:0]  aarsize_i = 3'd0;
    logic        postexec_i = 1'b0;
    logic        transfer_i = 1'b0;
    logic        write_i = 1'b0;
    logic [15:0] regno_i = 16'd0;
    logic        unsupported_i = 1'b0;
    logic        halted_i = 1'b1;
    logic        cmderr_clear_i = 1'b0;
    logic [31:0] data0_i = 32'd0;
    logic [31:0] data0_o;
    logic        data0_we_o;
    logic        reg_req_o;
    logic        reg_we_o;
    logic [15:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_gnt_i = 1'b0;
    logic        reg_rvalid_i = 1'b0;
    logic [31:0] reg_rdata_i = 32'd0;
    logic        reg_err_i = 1'b0;
    logic        exec_req_o;
    logic        exec_ack_i = 1'b0;
    logic        exec_done_i = 1'b0;
    logic        exec_exc_i = 1'b0;
    logic        busy_o;
    cmderr_e     cmderr_o;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_d0[$];
    req_t        mr;
    logic [31:0] md;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [2:0]  mdl_err = 3'd0;
    bit          exec_allowed = 1'b0;

    abstract_cmd_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_type_i(cmd_type_i),
        .aarsize_i(aarsize_i), .postexec_i(postexec_i), .transfer_i(transfer_i), .write_i(write_i),
        .regno_i(regno_i), .unsupported_i(unsupported_i), .halted_i(halted_i),
        .cmderr_clear_i(cmderr_clear_i), .data0_i(data0_i), .data0_o(data0_o), .data0_we_o(data0_we_o),
        .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
        .reg_gnt_i(reg_gnt_i), .reg_rvalid_i(reg_rvalid_i), .reg_rdata_i(reg_rdata_i), .reg_err_i(reg_err_i),
        .exec_req_o(exec_req_o), .exec_ack_i(exec_ack_i), .exec_done_i(exec_done_i), .exec_exc_i(exec_exc_i),
        .busy_o(busy_o), .cmderr_o(cmderr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] fit(input logic [2:0] s, input logic [31:0] v);
        return s == 3'd0 ? v % 32'd256 : s == 3'd1 ? v % 32'd65536 : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    task automatic miss(input string nm);
        n_chk++;
        $display("FAIL %s actual=event required=none", nm);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk_i);
        while (busy_o && n < 2000) begin
            n++;
            @(negedge clk_i);
        end
        if (busy_o) miss("idle_timeout");
    endtask

    task automatic clr();
        cmderr_clear_i = 1'b1;
        cyc();
        cmderr_clear_i = 1'b0;
        mdl_err = 3'd0;
        @(negedge clk_i);
        chk("cmderr_clear", 32'(cmderr_o), 32'd0);
    endtask

    // Monitor: compare each request acceptance and data0 write against the scoreboard
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (reg_req_o && reg_gnt_i) begin
                if (exp_req.size() == 0) miss("unexpected_req");
                else begin
                    mr = exp_req.pop_front();
                    chk("req_we", 32'(reg_we_o), 32'(mr.we));
                    chk("req_addr", 32'(reg_addr_o), 32'(mr.addr));
                    chk("req_wdata", reg_wdata_o, mr.wdata);
                end
            end
            if (data0_we_o) begin
                if (exp_d0.size() == 0) miss("unexpected_data0_we");
                else begin
                    md = exp_d0.pop_front();
                    chk("data0", data0_o, md);
                end
            end
            if (exec_req_o) chk("exec_req_window", 32'(exec_allowed), 32'd1);
        end
    end

    task automatic run_cmd(input bit tr, wr, pe, uns, hal, input logic [2:0] sz, input logic [15:0] rn,
                           input logic [31:0] d0, rdat, input bit rerr, input int gd, rd,
                           input bit poke, input int ad, dd, input bit exc);
        bit busy_exp;
        bit do_exec;
        int n;
        busy_exp = 1'b0;
        if (mdl_err != 3'd0) busy_exp = 1'b0;
        else if (uns) mdl_err = 3'd2;
        else if (!hal) mdl_err = 3'd4;
        else if (tr || pe) busy_exp = 1'b1;
        if (busy_exp && tr) exp_req.push_back('{wr, rn, fit(sz, d0)});
        if (busy_exp && !tr) exec_allowed = 1'b1;
        transfer_i = tr; write_i = wr; postexec_i = pe; unsupported_i = uns; halted_i = hal;
        aarsize_i = sz; regno_i = rn; data0_i = d0; cmd_valid_i = 1'b1;
        cyc();
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        chk("busy_after_issue", 32'(busy_o), 32'(busy_exp));
        if (!busy_exp) begin
            chk("cmderr_reject", 32'(cmderr_o), 32'(mdl_err));
            return;
        end
        if (poke) begin
            cmd_valid_i = 1'b1;
            cyc();
            cmd_valid_i = 1'b0;
            if (mdl_err == 3'd0) mdl_err = 3'd1;
        end
        do_exec = pe;
        if (tr) begin
            if (gd < 0) begin
                wait_idle(n);
                chk("timeout_span", 32'(n >= 1023 && n <= 1026), 32'd1);
                if (mdl_err == 3'd0) mdl_err = 3'd7;
                chk("cmderr_timeout", 32'(cmderr_o), 32'(mdl_err));
                exp_req.delete();
                exec_allowed = 1'b0;
                return;
            end
            repeat (gd - int'(poke)) cyc();
            reg_gnt_i = 1'b1;
            cyc();
            reg_gnt_i = 1'b0;
            repeat (rd) cyc();
            reg_rvalid_i = 1'b1; reg_rdata_i = rdat; reg_err_i = rerr;
            if (!wr && !rerr) exp_d0.push_back(fit(sz, rdat));
            if (rerr) begin
                if (mdl_err == 3'd0) mdl_err = 3'd3;
                do_exec = 1'b0;
            end else if (pe) exec_allowed = 1'b1;
            cyc();
            reg_rvalid_i = 1'b0; reg_err_i = 1'b0;
        end
        if (do_exec) begin
            n = 0;
            while (!exec_req_o && n < 20) begin
                cyc();
                n++;
            end
            chk("exec_req_seen", 32'(exec_req_o), 32'd1);
            repeat (ad) cyc();
            exec_ack_i = 1'b1;
            cyc();
            exec_ack_i = 1'b0;
            exec_allowed = 1'b0;
            repeat (dd) cyc();
            exec_done_i = 1'b1; exec_exc_i = exc;
            if (exc && mdl_err == 3'd0) mdl_err = 3'd3;
            cyc();
            exec_done_i = 1'b0; exec_exc_i = 1'b0;
        end
        wait_idle(n);
        exec_allowed = 1'b0;
        chk("cmderr_final", 32'(cmderr_o), 32'(mdl_err));
    endtask

    initial begin
        bit tr, wr, pe, uns, hal, rerr, poke, exc;
        logic [2:0] sz;
        repeat (2) cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cmderr", 32'(cmderr_o), 32'd0);
        chk("rst_req", 32'(reg_req_o), 32'd0);
        chk("rst_exec", 32'(exec_req_o), 32'd0);
        chk("rst_data0", data0_o, 32'd0);

        run_cmd(1, 0, 0, 0, 1, 3'd2, 16'h1008, 32'h0, 32'hDEADBEEF, 0, 1, 1, 0, 0, 0, 0);
        run_cmd(1, 1, 1, 0, 1, 3'd0, 16'h1001, 32'h12345678, 32'h0, 0, 1, 1, 0, 1, 4, 0);
        run_cmd(1, 0, 0, 1, 1, 3'd2, 16'h0005, 32'h0, 32'h1, 0, 1, 1, 0, 0, 0, 0);
        run_cmd(1, 0, 0, 0, 1, 3'd2, 16'h0006, 32'h0, 32'h2, 0, 1, 1, 0, 0, 0, 0);
        clr();
        run_cmd(1, 0, 0, 0, 1, 3'd1, 16'h0300, 32'h0, 32'hCAFEF00D, 0, 2, 1, 1, 0, 0, 0);
        clr();
        run_cmd(1, 0, 0, 0, 1, 3'd2, 16'h0007, 32'h0, 32'h0, 0, -1, 0, 0, 0, 0, 0);
        clr();
        run_cmd(1, 0, 1, 0, 1, 3'd2, 16'h0008, 32'h0, 32'h55, 1, 1, 1, 0, 0, 0, 0);
        clr();
        run_cmd(1, 0, 0, 0, 0, 3'd2, 16'h0009, 32'h0, 32'h0, 0, 1, 1, 0, 0, 0, 0);
        clr();
        run_cmd(0, 0, 1, 0, 1, 3'd0, 16'h0000, 32'h0, 32'h0, 0, 1, 1, 0, 1, 2, 1);
        clr();
        run_cmd(0, 0, 1, 0, 1, 3'd0, 16'h0000, 32'h0, 32'h0, 0, 1, 1, 0, 0, 1, 0);

        // reset while a read response is outstanding
        exp_req.push_back('{1'b0, 16'h1010, 32'h0});
        transfer_i = 1'b1; write_i = 1'b0; postexec_i = 1'b0; unsupported_i = 1'b0; halted_i = 1'b1;
        aarsize_i = 3'd2; regno_i = 16'h1010; data0_i = 32'h0; cmd_valid_i = 1'b1;
        cyc();
        cmd_valid_i = 1'b0;
        reg_gnt_i = 1'b1;
        cyc();
        reg_gnt_i = 1'b0;
        cyc();
        #2 rst_i = 1'b1;
        #1;
        exp_req.delete();
        exp_d0.delete();
        mdl_err = 3'd0;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_req", 32'(reg_req_o), 32'd0);
        chk("midrst_addr", 32'(reg_addr_o), 32'd0);
        chk("midrst_we", 32'(data0_we_o), 32'd0);
        chk("midrst_cmderr", 32'(cmderr_o), 32'd0);
        cyc();
        rst_i = 1'b0;
        reg_rvalid_i = 1'b1; reg_rdata_i = 32'h0BADF00D;
        @(negedge clk_i);
        chk("late_rvalid_we", 32'(data0_we_o), 32'd0);
        chk("late_rvalid_busy", 32'(busy_o), 32'd0);
        cyc();
        reg_rvalid_i = 1'b0;

        for (int i = 0; i < 40; i++) begin
            if (mdl_err != 3'd0 && $urandom_range(0, 2) != 0) clr();
            tr   = $urandom_range(0, 9) < 8;
            wr   = $urandom_range(0, 1) == 1;
            pe   = $urandom_range(0, 9) < 3;
            uns  = $urandom_range(0, 9) == 0;
            hal  = $urandom_range(0, 9) != 0;
            rerr = $urandom_range(0, 9) < 2;
            poke = tr && $urandom_range(0, 9) == 0;
            exc  = $urandom_range(0, 9) < 2;
            sz   = 3'($urandom_range(0, 2));
            run_cmd(tr, wr, pe, uns, hal, sz, 16'($urandom_range(0, 65535)), $urandom, $urandom, rerr,
                    $urandom_range(1, 3), $urandom_range(0, 3), poke, $urandom_range(0, 3),
                    $urandom_range(0, 5), exc);
        end

        chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
        chk("data0_queue_drained", 32'(exp_d0.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
